// File: rtl/div_issue_arbiter.sv
// -----------------------------------------------------------------------------
// div_issue_arbiter
//
// Purpose:
//   Shares the single divider_manager push port between two issue pipes
//   (P0, P1). Each pipe owns a 1-entry request buffer; a round-robin arbiter
//   forwards one buffered request per handshake to the divider. Once a
//   request is offered and stalled, the choice is locked so that the operands
//   seen by the divider stay stable until the handshake (or a flush).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid_i[1:0]    per-pipe request valid (bit p = pipe p)
//   req_ready_o[1:0]    per-pipe buffer free
//   req_r0_i/req_r1_i   dividend/divisor per pipe, pipe p at [p*DATA_W +: DATA_W]
//   req_unsigned_i      unsigned-op flag per pipe
//   req_id_i            tag per pipe, pipe p at [p*ID_W +: ID_W]
//   flush_i             drops buffered, unissued requests; blocks pushes
//   div_push_valid_o    to divider_manager.push_valid_i
//   div_push_ready_i    from divider_manager.push_ready_o
//   div_r0_o/div_r1_o   selected operands
//   div_unsigned_o      selected unsigned flag
//   div_id_o            selected tag
//   div_grant_o         pipe index of the current push
//   perf_conflict_o     (DIV_ARB_PERF_EN only) cycles with both buffers full
//   perf_stall_o        (DIV_ARB_PERF_EN only) cycles with valid & ~ready
//
// Configuration macro: DIV_ARB_PERF_EN adds the two saturating perf counters.
// -----------------------------------------------------------------------------
module div_issue_arbiter #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 3,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [2*DATA_W-1:0] req_r0_i,
  input  logic [2*DATA_W-1:0] req_r1_i,
  input  logic [1:0]          req_unsigned_i,
  input  logic [2*ID_W-1:0]   req_id_i,
  input  logic                flush_i,
  output logic                div_push_valid_o,
  input  logic                div_push_ready_i,
  output logic [DATA_W-1:0]   div_r0_o,
  output logic [DATA_W-1:0]   div_r1_o,
  output logic                div_unsigned_o,
  output logic [ID_W-1:0]     div_id_o,
  output logic                div_grant_o
`ifdef DIV_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]    perf_conflict_o,
  output logic [CNT_W-1:0]    perf_stall_o
`endif
);

  logic [1:0]          buf_vld_reg;
  logic                rr_reg;
  logic                lock_reg;
  logic                lock_sel_reg;
  logic                sel;
  logic                handshake;
  logic [1:0]          accept;
  logic [1:0]          hs_mask;

  // Buffer contents flattened so the selected pipe can be picked by part-select.
  logic [2*DATA_W-1:0] buf_r0_flat;
  logic [2*DATA_W-1:0] buf_r1_flat;
  logic [1:0]          buf_uns_flat;
  logic [2*ID_W-1:0]   buf_id_flat;

  // A buffer only accepts when empty, so a pipe that handshakes this cycle
  // cannot be refilled until the next one.
  assign req_ready_o = ~buf_vld_reg;
  assign accept      = req_valid_i & ~buf_vld_reg & {2{~flush_i}};

  // Per-pipe payload storage.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pipe
      logic [DATA_W-1:0] r0_reg;
      logic [DATA_W-1:0] r1_reg;
      logic              uns_reg;
      logic [ID_W-1:0]   id_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r0_reg  <= '0;
          r1_reg  <= '0;
          uns_reg <= 1'b0;
          id_reg  <= '0;
        end else if (accept[gi]) begin
          r0_reg  <= req_r0_i[gi*DATA_W +: DATA_W];
          r1_reg  <= req_r1_i[gi*DATA_W +: DATA_W];
          uns_reg <= req_unsigned_i[gi];
          id_reg  <= req_id_i[gi*ID_W +: ID_W];
        end
      end

      assign buf_r0_flat[gi*DATA_W +: DATA_W] = r0_reg;
      assign buf_r1_flat[gi*DATA_W +: DATA_W] = r1_reg;
      assign buf_uns_flat[gi]                 = uns_reg;
      assign buf_id_flat[gi*ID_W +: ID_W]     = id_reg;
    end
  endgenerate

  // Select: a stalled offer keeps its pipe; otherwise a lone request wins and
  // a tie goes to the round-robin pointer.
  always_comb begin
    sel = rr_reg;
    if (lock_reg) begin
      sel = lock_sel_reg;
    end else if (buf_vld_reg == 2'b01) begin
      sel = 1'b0;
    end else if (buf_vld_reg == 2'b10) begin
      sel = 1'b1;
    end
  end

  assign div_push_valid_o = (|buf_vld_reg) & ~flush_i;
  assign handshake        = div_push_valid_o & div_push_ready_i;
  assign hs_mask          = handshake ? (sel ? 2'b10 : 2'b01) : 2'b00;

  assign div_r0_o       = buf_r0_flat[sel*DATA_W +: DATA_W];
  assign div_r1_o       = buf_r1_flat[sel*DATA_W +: DATA_W];
  assign div_unsigned_o = buf_uns_flat[sel];
  assign div_id_o       = buf_id_flat[sel*ID_W +: ID_W];
  assign div_grant_o    = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_vld_reg  <= 2'b00;
      rr_reg       <= 1'b0;
      lock_reg     <= 1'b0;
      lock_sel_reg <= 1'b0;
    end else if (flush_i) begin
      // Flush drops everything not yet issued; fairness history is kept.
      buf_vld_reg <= 2'b00;
      lock_reg    <= 1'b0;
    end else begin
      buf_vld_reg <= (buf_vld_reg & ~hs_mask) | accept;
      if (handshake) begin
        rr_reg   <= ~sel;
        lock_reg <= 1'b0;
      end else if (div_push_valid_o) begin
        lock_reg     <= 1'b1;
        lock_sel_reg <= sel;
      end
    end
  end

`ifdef DIV_ARB_PERF_EN
  logic conflict;
  logic stall;
  assign conflict = &buf_vld_reg;
  assign stall    = div_push_valid_o & ~div_push_ready_i;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_conflict_o <= '0;
      perf_stall_o    <= '0;
    end else begin
      if (conflict && (perf_conflict_o != '1)) begin
        perf_conflict_o <= perf_conflict_o + 1'b1;
      end
      if (stall && (perf_stall_o != '1)) begin
        perf_stall_o <= perf_stall_o + 1'b1;
      end
    end
  end
`else
  // CNT_W only sizes the perf counters; nothing is built from it here.
  if (CNT_W < 1) begin : g_no_perf
  end
`endif

endmodule
